// File: rtl/pb_dummy_tile_responder.sv
// Dummy NoC tile: accepts request flits on independent channels and either drops
// them or answers each transaction with DECERR beats routed back to the requester.
module pb_dummy_tile_responder #(
  parameter int NumChannels = 2,
  parameter int CoordWidth  = 4,
  parameter int IdWidth     = 4,
  parameter int LenWidth    = 8,
  parameter int FifoDepth   = 4,
  parameter int CntWidth    = 16,
  parameter int RespMode    = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumChannels-1:0]                req_valid_i,
  output logic [NumChannels-1:0]                req_ready_o,
  input  logic [NumChannels-1:0][CoordWidth-1:0] req_src_x_i,
  input  logic [NumChannels-1:0][CoordWidth-1:0] req_src_y_i,
  input  logic [NumChannels-1:0][IdWidth-1:0]    req_id_i,
  input  logic [NumChannels-1:0]                req_write_i,
  input  logic [NumChannels-1:0][LenWidth-1:0]   req_len_i,
  input  logic [NumChannels-1:0]                req_last_i,
  output logic [NumChannels-1:0]                rsp_valid_o,
  input  logic [NumChannels-1:0]                rsp_ready_i,
  output logic [NumChannels-1:0][CoordWidth-1:0] rsp_dst_x_o,
  output logic [NumChannels-1:0][CoordWidth-1:0] rsp_dst_y_o,
  output logic [NumChannels-1:0][IdWidth-1:0]    rsp_id_o,
  output logic [NumChannels-1:0]                rsp_write_o,
  output logic [NumChannels-1:0]                rsp_last_o,
  output logic [NumChannels-1:0][1:0]           rsp_err_o,
  input  logic                                  cnt_clear_i,
  output logic [NumChannels-1:0][CntWidth-1:0]   err_cnt_o
);

  // Handshake: a beat transfers on a rising clock edge where valid and ready are
  // both high; the sender holds valid and payload stable until that edge.

  localparam int PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int FillW = $clog2(FifoDepth + 1);

  typedef enum logic {S_IDLE, S_RESP} state_e;

  typedef struct packed {
    logic [CoordWidth-1:0] x;
    logic [CoordWidth-1:0] y;
    logic [IdWidth-1:0]    id;
    logic                  write;
    logic [LenWidth-1:0]   len;
  } entry_t;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FillW-1:0]      fill_q, fill_d;
    entry_t                mem_q [FifoDepth];
    entry_t                mem_d [FifoDepth];
    logic                  burst_q, burst_d;
    logic [CoordWidth-1:0] hdr_x_q, hdr_x_d, hdr_y_q, hdr_y_d;
    logic [IdWidth-1:0]    hdr_id_q, hdr_id_d;
    state_e                state_q, state_d;
    entry_t                out_q, out_d;
    logic [LenWidth-1:0]   beat_q, beat_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  full, empty, ready, accept, intake, push, pop;
    logic                  rsp_valid, last_beat;
    entry_t                push_entry;

    // The pop of the last response beat frees its entry only on the following cycle.
    assign full      = (fill_q == FillW'(FifoDepth));
    assign empty     = (fill_q == '0);
    assign accept    = req_valid_i[c] & ready;
    assign intake    = accept & (~req_write_i[c] | req_last_i[c]);
    assign push      = (RespMode != 0) & intake;
    assign rsp_valid = (state_q == S_RESP);
    assign last_beat = out_q.write | (beat_q == out_q.len);
    assign pop       = rsp_valid & rsp_ready_i[c] & last_beat;

    always_comb begin
      ready = 1'b1;
      if (RespMode != 0 && !(req_write_i[c] && !req_last_i[c])) ready = !full;
    end

    always_comb begin
      push_entry       = '0;
      push_entry.write = req_write_i[c];
      push_entry.len   = req_write_i[c] ? '0 : req_len_i[c];
      if (req_write_i[c] && burst_q) begin
        push_entry.x  = hdr_x_q;
        push_entry.y  = hdr_y_q;
        push_entry.id = hdr_id_q;
      end else begin
        push_entry.x  = req_src_x_i[c];
        push_entry.y  = req_src_y_i[c];
        push_entry.id = req_id_i[c];
      end
    end

    always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push) begin
        mem_d[wptr_q] = push_entry;
        wptr_d        = ptr_inc(wptr_q);
      end
      if (pop) rptr_d = ptr_inc(rptr_q);
      fill_d = fill_q + FillW'(push) - FillW'(pop);
    end

    always_comb begin
      burst_d  = burst_q;
      hdr_x_d  = hdr_x_q;
      hdr_y_d  = hdr_y_q;
      hdr_id_d = hdr_id_q;
      if (accept && req_write_i[c]) begin
        if (req_last_i[c]) begin
          burst_d = 1'b0;
        end else if (!burst_q) begin
          burst_d  = 1'b1;
          hdr_x_d  = req_src_x_i[c];
          hdr_y_d  = req_src_y_i[c];
          hdr_id_d = req_id_i[c];
        end
      end
    end

    always_comb begin
      state_d = state_q;
      out_d   = out_q;
      beat_d  = beat_q;
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            out_d   = mem_q[rptr_q];
            beat_d  = '0;
            state_d = S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready_i[c]) begin
            if (last_beat) state_d = S_IDLE;
            else           beat_d  = beat_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Clear wins over the old value but not over an intake in the same cycle.
    always_comb begin
      cnt_d = cnt_q;
      if (cnt_clear_i)                 cnt_d = intake ? CntWidth'(1) : '0;
      else if (intake && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wptr_q   <= '0;
        rptr_q   <= '0;
        fill_q   <= '0;
        for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
        burst_q  <= 1'b0;
        hdr_x_q  <= '0;
        hdr_y_q  <= '0;
        hdr_id_q <= '0;
        state_q  <= S_IDLE;
        out_q    <= '0;
        beat_q   <= '0;
        cnt_q    <= '0;
      end else begin
        wptr_q   <= wptr_d;
        rptr_q   <= rptr_d;
        fill_q   <= fill_d;
        mem_q    <= mem_d;
        burst_q  <= burst_d;
        hdr_x_q  <= hdr_x_d;
        hdr_y_q  <= hdr_y_d;
        hdr_id_q <= hdr_id_d;
        state_q  <= state_d;
        out_q    <= out_d;
        beat_q   <= beat_d;
        cnt_q    <= cnt_d;
      end
    end

    assign req_ready_o[c] = ready;
    assign rsp_valid_o[c] = rsp_valid;
    assign rsp_dst_x_o[c] = out_q.x;
    assign rsp_dst_y_o[c] = out_q.y;
    assign rsp_id_o[c]    = out_q.id;
    assign rsp_write_o[c] = out_q.write;
    assign rsp_last_o[c]  = rsp_valid & last_beat;
    assign rsp_err_o[c]   = rsp_valid ? 2'b11 : 2'b00;
    assign err_cnt_o[c]   = cnt_q;
  end

endmodule

// File: tb/tb_pb_dummy_tile_responder.sv
// Bench for pb_dummy_tile_responder: a responding instance (small FIFO, 3-bit counters)
// and a dropping instance, checked every cycle against a transaction-level model.
module tb_pb_dummy_tile_responder;

  logic clk;
  logic rst_n;

  // Responding instance
  logic [1:0]       req_valid, req_ready, req_write, req_last;
  logic [1:0][3:0]  req_src_x, req_src_y, req_id;
  logic [1:0][7:0]  req_len;
  logic [1:0]       rsp_valid, rsp_ready, rsp_write, rsp_last;
  logic [1:0][3:0]  rsp_dst_x, rsp_dst_y, rsp_id;
  logic [1:0][1:0]  rsp_err;
  logic             cnt_clear;
  logic [1:0][2:0]  err_cnt;

  // Dropping instance
  logic [1:0]       d_valid, d_ready, d_write, d_last;
  logic [1:0][3:0]  d_src_x, d_src_y, d_id;
  logic [1:0][7:0]  d_len;
  logic [1:0]       d_rsp_valid, d_rsp_ready, d_rsp_write, d_rsp_last;
  logic [1:0][3:0]  d_rsp_dst_x, d_rsp_dst_y, d_rsp_id;
  logic [1:0][1:0]  d_rsp_err;
  logic             d_clear;
  logic [1:0][3:0]  d_err_cnt;

  int checks   = 0;
  int failures = 0;

  // Expected response beats per channel: {x, y, id, write, last}
  logic [13:0] exp_q0[$];
  logic [13:0] exp_q1[$];
  int          outst[2];
  logic        in_burst[2];
  logic [3:0]  hx[2], hy[2], hid[2];
  int          cnt_m[2];
  int          d_cnt_m[2];

  pb_dummy_tile_responder #(
    .NumChannels(2), .CoordWidth(4), .IdWidth(4), .LenWidth(8),
    .FifoDepth(2), .CntWidth(3), .RespMode(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_src_x_i(req_src_x), .req_src_y_i(req_src_y), .req_id_i(req_id),
    .req_write_i(req_write), .req_len_i(req_len), .req_last_i(req_last),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_dst_x_o(rsp_dst_x), .rsp_dst_y_o(rsp_dst_y), .rsp_id_o(rsp_id),
    .rsp_write_o(rsp_write), .rsp_last_o(rsp_last), .rsp_err_o(rsp_err),
    .cnt_clear_i(cnt_clear), .err_cnt_o(err_cnt)
  );

  pb_dummy_tile_responder #(
    .NumChannels(2), .CoordWidth(4), .IdWidth(4), .LenWidth(8),
    .FifoDepth(2), .CntWidth(4), .RespMode(0)
  ) dut_drop (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(d_valid), .req_ready_o(d_ready),
    .req_src_x_i(d_src_x), .req_src_y_i(d_src_y), .req_id_i(d_id),
    .req_write_i(d_write), .req_len_i(d_len), .req_last_i(d_last),
    .rsp_valid_o(d_rsp_valid), .rsp_ready_i(d_rsp_ready),
    .rsp_dst_x_o(d_rsp_dst_x), .rsp_dst_y_o(d_rsp_dst_y), .rsp_id_o(d_rsp_id),
    .rsp_write_o(d_rsp_write), .rsp_last_o(d_rsp_last), .rsp_err_o(d_rsp_err),
    .cnt_clear_i(d_clear), .err_cnt_o(d_err_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int c);
    return (c == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic void qpush(input int c, input logic [13:0] v);
    if (c == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endfunction

  function automatic logic [13:0] qfront(input int c);
    return (c == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  function automatic void qpop(input int c);
    if (c == 0) void'(exp_q0.pop_front());
    else        void'(exp_q1.pop_front());
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input int ch, input logic w, input logic l,
                            input logic [3:0] x, input logic [3:0] y,
                            input logic [3:0] id, input logic [7:0] len);
    int n;
    n = 0;
    @(negedge clk);
    req_valid[ch] = 1'b1;
    req_write[ch] = w;
    req_last[ch]  = l;
    req_src_x[ch] = x;
    req_src_y[ch] = y;
    req_id[ch]    = id;
    req_len[ch]   = len;
    #2;
    while (!req_ready[ch] && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= 100) chk("drive_timeout", n, 0);
    @(posedge clk);
    #1;
    req_valid[ch] = 1'b0;
  endtask

  task automatic d_beat(input int ch, input logic w, input logic l, input logic clr);
    @(negedge clk);
    d_valid[ch] = 1'b1;
    d_write[ch] = w;
    d_last[ch]  = l;
    d_clear     = clr;
    d_src_x[ch] = 4'($urandom_range(0, 15));
    d_src_y[ch] = 4'($urandom_range(0, 15));
    d_id[ch]    = 4'($urandom_range(0, 15));
    d_len[ch]   = 8'($urandom_range(0, 3));
    @(posedge clk);
    #1;
    d_valid[ch] = 1'b0;
    d_clear     = 1'b0;
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    logic        exp_rdy;
    logic [13:0] act;
    logic [13:0] front;
    logic        inc;
    logic        dinc;
    #1;
    if (!rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
      for (int c = 0; c < 2; c++) begin
        outst[c]    = 0;
        in_burst[c] = 1'b0;
        cnt_m[c]    = 0;
        d_cnt_m[c]  = 0;
      end
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_req_ready", req_ready, 2'b11);
      chk("rst_d_err_cnt", d_err_cnt, 0);
    end else begin
      for (int c = 0; c < 2; c++) begin
        // responding instance
        exp_rdy = (req_write[c] && !req_last[c]) ? 1'b1 : (outst[c] < 2);
        chk("req_ready", req_ready[c], exp_rdy);
        chk("rsp_err", rsp_err[c], rsp_valid[c] ? 2'b11 : 2'b00);
        if (rsp_valid[c]) begin
          act = {rsp_dst_x[c], rsp_dst_y[c], rsp_id[c], rsp_write[c], rsp_last[c]};
          if (qsize(c) == 0) begin
            chk("rsp_unexpected", rsp_valid[c], 0);
          end else begin
            front = qfront(c);
            chk("rsp_beat", act, front);
            if (rsp_ready[c]) begin
              qpop(c);
              if (front[0]) outst[c]--;
            end
          end
        end
        inc = 1'b0;
        if (req_valid[c] && exp_rdy) begin
          if (req_write[c]) begin
            if (req_last[c]) begin
              if (in_burst[c]) qpush(c, {hx[c], hy[c], hid[c], 2'b11});
              else             qpush(c, {req_src_x[c], req_src_y[c], req_id[c], 2'b11});
              in_burst[c] = 1'b0;
              outst[c]++;
              inc = 1'b1;
            end else if (!in_burst[c]) begin
              hx[c]       = req_src_x[c];
              hy[c]       = req_src_y[c];
              hid[c]      = req_id[c];
              in_burst[c] = 1'b1;
            end
          end else begin
            for (int b = 0; b <= int'(req_len[c]); b++)
              qpush(c, {req_src_x[c], req_src_y[c], req_id[c], 1'b0, (b == int'(req_len[c]))});
            outst[c]++;
            inc = 1'b1;
          end
        end
        chk("err_cnt", err_cnt[c], cnt_m[c]);
        if (cnt_clear)               cnt_m[c] = inc ? 1 : 0;
        else if (inc && cnt_m[c] < 7) cnt_m[c]++;

        // dropping instance
        dinc = d_valid[c] && (!d_write[c] || d_last[c]);
        chk("d_req_ready", d_ready[c], 1);
        chk("d_rsp_valid", d_rsp_valid[c], 0);
        chk("d_rsp_fields", {d_rsp_dst_x[c], d_rsp_dst_y[c], d_rsp_id[c], d_rsp_write[c],
                             d_rsp_last[c], d_rsp_err[c]}, 0);
        chk("d_err_cnt", d_err_cnt[c], d_cnt_m[c]);
        if (d_clear)                   d_cnt_m[c] = dinc ? 1 : 0;
        else if (dinc && d_cnt_m[c] < 15) d_cnt_m[c]++;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int         left[2];
    logic [1:0] acc;
    int         n;

    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_last = '0;
    req_src_x = '0; req_src_y = '0; req_id = '0; req_len = '0;
    rsp_ready = '0; cnt_clear = 1'b0;
    d_valid = '0; d_write = '0; d_last = '0;
    d_src_x = '0; d_src_y = '0; d_id = '0; d_len = '0;
    d_rsp_ready = 2'b11; d_clear = 1'b0;
    left[0] = 0; left[1] = 0; acc = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_req_ready", req_ready, 2'b11);
    chk("reset_err_cnt0", err_cnt[0], 0);

    // Read (3,1) id 5 len 3: four beats from two cycles after acceptance
    rsp_ready = 2'b11;
    drive_beat(0, 1'b0, 1'b1, 4'd3, 4'd1, 4'd5, 8'd3);
    @(negedge clk); #1;
    chk("read_lat_t1", rsp_valid[0], 0);
    chk("read_err_cnt", err_cnt[0], 1);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); #1;
      chk("read_valid", rsp_valid[0], 1);
      chk("read_last", rsp_last[0], (b == 3));
      chk("read_dst_id", {rsp_dst_x[0], rsp_dst_y[0], rsp_id[0]}, 12'h315);
      chk("read_err", rsp_err[0], 2'b11);
      chk("read_write", rsp_write[0], 0);
    end
    @(negedge clk); #1;
    chk("read_done", rsp_valid[0], 0);

    // Three-beat write; later beats carry other ids/sources
    drive_beat(0, 1'b1, 1'b0, 4'd0, 4'd2, 4'd9, 8'd0);
    drive_beat(0, 1'b1, 1'b0, 4'd7, 4'd7, 4'd3, 8'd0);
    drive_beat(0, 1'b1, 1'b1, 4'd7, 4'd7, 4'd12, 8'd0);
    @(negedge clk); #1;
    chk("wr_lat_t1", rsp_valid[0], 0);
    @(negedge clk); #1;
    chk("wr_b_valid", rsp_valid[0], 1);
    chk("wr_b_fields", {rsp_dst_x[0], rsp_dst_y[0], rsp_id[0], rsp_write[0], rsp_last[0]},
        {4'd0, 4'd2, 4'd9, 2'b11});
    @(negedge clk); #1;
    chk("wr_single_b", rsp_valid[0], 0);

    // Full FIFO: third read blocked until the first response pops
    rsp_ready[0] = 1'b0;
    drive_beat(0, 1'b0, 1'b1, 4'd1, 4'd1, 4'd1, 8'd0);
    drive_beat(0, 1'b0, 1'b1, 4'd2, 4'd2, 4'd2, 8'd1);
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_last[0] = 1'b1;
    req_src_x[0] = 4'd3; req_src_y[0] = 4'd3; req_id[0] = 4'd3; req_len[0] = 8'd0;
    #2;
    chk("fifo_full_blocks", req_ready[0], 0);
    repeat (2) begin
      @(negedge clk); #2;
      chk("fifo_full_holds", req_ready[0], 0);
    end
    @(negedge clk);
    rsp_ready[0] = 1'b1;
    #2;
    chk("pop_same_cycle", req_ready[0], 0);
    @(negedge clk); #2;
    chk("ready_after_pop", req_ready[0], 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (8) @(negedge clk);
    chk("fifo_drained", exp_q0.size(), 0);

    // Reset in the middle of a response and a write burst
    rsp_ready[0] = 1'b0;
    drive_beat(0, 1'b0, 1'b1, 4'd9, 4'd9, 4'd4, 8'd2);
    drive_beat(0, 1'b1, 1'b0, 4'd4, 4'd4, 4'd10, 8'd0);
    drive_beat(0, 1'b1, 1'b0, 4'd4, 4'd4, 4'd11, 8'd0);
    @(negedge clk); #1;
    chk("pre_reset_valid", rsp_valid[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", rsp_valid, 0);
    chk("async_rst_cnt", err_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready[0] = 1'b1;
    drive_beat(0, 1'b1, 1'b1, 4'd5, 4'd6, 4'd7, 8'd0);
    @(negedge clk); #1;
    chk("post_rst_idle", rsp_valid[0], 0);
    @(negedge clk); #1;
    chk("post_rst_valid", rsp_valid[0], 1);
    chk("post_rst_fields", {rsp_dst_x[0], rsp_dst_y[0], rsp_id[0], rsp_write[0], rsp_last[0]},
        {4'd5, 4'd6, 4'd7, 2'b11});

    // Randomized traffic on both channels; channel 1 starved of rsp_ready first
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      rsp_ready[0] = ($urandom_range(0, 3) != 0);
      rsp_ready[1] = (cyc < 750) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 4) != 0);
      cnt_clear    = ($urandom_range(0, 19) == 0);
      for (int c = 0; c < 2; c++) begin
        if (!req_valid[c] || acc[c]) begin
          req_valid[c] = 1'b0;
          if (left[c] > 0) begin
            if ($urandom_range(0, 4) != 0) begin
              req_valid[c] = 1'b1;
              req_write[c] = 1'b1;
              req_last[c]  = (left[c] == 1);
              req_src_x[c] = 4'($urandom_range(0, 15));
              req_src_y[c] = 4'($urandom_range(0, 15));
              req_id[c]    = 4'($urandom_range(0, 15));
              req_len[c]   = 8'($urandom_range(0, 255));
              left[c]--;
            end
          end else if ($urandom_range(0, 9) < 6) begin
            req_valid[c] = 1'b1;
            req_src_x[c] = 4'($urandom_range(0, 15));
            req_src_y[c] = 4'($urandom_range(0, 15));
            req_id[c]    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
              req_write[c] = 1'b0;
              req_last[c]  = 1'b1;
              req_len[c]   = 8'($urandom_range(0, 3));
            end else begin
              n            = $urandom_range(1, 3);
              req_write[c] = 1'b1;
              req_last[c]  = (n == 1);
              req_len[c]   = 8'($urandom_range(0, 255));
              left[c]      = n - 1;
            end
          end
        end
      end
      #2;
      acc = req_valid & req_ready;
    end
    @(negedge clk);
    req_valid = '0;
    cnt_clear = 1'b0;
    rsp_ready = 2'b11;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_ch0", exp_q0.size(), 0);
    chk("drain_ch1", exp_q1.size(), 0);

    // Drop mode: 10 completed intakes among 13 beats, then saturation and clear
    for (int i = 0; i < 13; i++) begin
      if (i % 4 == 1)      d_beat(0, 1'b1, 1'b0, 1'b0);
      else if (i % 4 == 3) d_beat(0, 1'b1, 1'b1, 1'b0);
      else                 d_beat(0, 1'b0, 1'b1, 1'b0);
    end
    chk("drop_cnt10", d_err_cnt[0], 10);
    chk("drop_cnt_ch1", d_err_cnt[1], 0);
    for (int i = 0; i < 8; i++) d_beat(0, 1'b0, 1'b1, 1'b0);
    chk("drop_cnt_sat", d_err_cnt[0], 15);
    d_beat(0, 1'b0, 1'b1, 1'b1);
    chk("clear_with_intake", d_err_cnt[0], 1);
    @(negedge clk);
    d_clear = 1'b1;
    @(posedge clk); #1;
    d_clear = 1'b0;
    chk("clear_alone", d_err_cnt[0], 0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pb_dummy_tile_responder.md
Name: pb_dummy_tile_responder

Overview:
- Terminates NoC traffic at mesh positions with no physical tile, and at mesh-edge tie-off ports.
- Accepts request flits on NumChannels independent channels.
- Either drops them silently, or returns AXI-style DECERR responses routed back to the requester's coordinates.
- Replaces passive tie-offs: misrouted or out-of-map accesses terminate instead of hanging the NoC, and per-channel error counters are exported.

Parameters:
- NumChannels, 2, number of independent request/response channel pairs.
- CoordWidth, 4, width of the x and y mesh coordinate fields.
- IdWidth, 4, transaction ID width.
- LenWidth, 8, burst length field width (beats minus one).
- FifoDepth, 4, pending-transaction FIFO entries per channel (≥1).
- CntWidth, 16, width of each saturating error counter.
- RespMode, 1, 0 = drop silently, 1 = DECERR responses.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  [NumChannels]  request beat valid.
- req_ready_o  out  [NumChannels]  request beat ready.
- req_src_x_i / req_src_y_i  in  [NumChannels][CoordWidth]  requester coordinates.
- req_id_i  in  [NumChannels][IdWidth]  transaction ID.
- req_write_i  in  [NumChannels]  1 = write beat, 0 = read request.
- req_len_i  in  [NumChannels][LenWidth]  burst length minus one; used for reads only.
- req_last_i  in  [NumChannels]  last write beat; must be 1 on reads.
- rsp_valid_o  out  [NumChannels]  response beat valid.
- rsp_ready_i  in  [NumChannels]  response beat ready.
- rsp_dst_x_o / rsp_dst_y_o  out  [NumChannels][CoordWidth]  destination, equal to the captured source.
- rsp_id_o  out  [NumChannels][IdWidth]  echoed ID.
- rsp_write_o  out  [NumChannels]  1 = B response, 0 = R beat.
- rsp_last_o  out  [NumChannels]  last response beat.
- rsp_err_o  out  [NumChannels][2]  constant 2'b11 (DECERR) while valid; 0 otherwise.
- cnt_clear_i  in  1  synchronous clear of all counters.
- err_cnt_o  out  [NumChannels][CntWidth]  completed-transaction counters.

Behaviour:
- Reset (async, rst_ni=0):
  - All FIFOs empty, FSMs in IDLE, burst flags clear, header registers 0, counters 0.
  - All rsp_* outputs 0. req_ready_o follows its combinational rule from the empty state.
- Channels are fully independent; no cross-channel arbitration.
- Write intake:
  - The first beat of a burst (burst flag clear) captures src_x, src_y and id into a header register and sets the flag.
  - Non-last beats: req_ready_o=1 unconditionally.
  - Last beat: requires a free FIFO entry (RespMode=1). On acceptance it enqueues {header, write=1, len=0} and clears the flag.
  - A single-beat write (first beat with last=1) enqueues that beat's own fields directly.
- Read intake: one beat. req_ready_o = !fifo_full. On acceptance it enqueues {src, id, write=0, len}.
- RespMode=0: req_ready_o=1 always, nothing is enqueued, rsp_valid_o stays 0. Counters still count.
- Response FSM per channel:
  - IDLE: if FIFO non-empty, load head into output registers, beat_cnt=0, go to RESP.
  - RESP: rsp_valid_o=1; outputs held stable while rsp_ready_i=0.
    - rsp_last_o = write | (beat_cnt==len).
    - On handshake with rsp_last_o=1: pop FIFO, go to IDLE.
    - On handshake otherwise: beat_cnt+1, stay in RESP.
- Latency, empty FIFO: request accepted at cycle t gives rsp_valid_o at t+2. One idle bubble between consecutive transactions.
- Simultaneous enqueue and pop on a full FIFO: the pop frees an entry only from the next cycle. The full flag is registered, so req_ready_o stays 0 that cycle.
- Counters:
  - Increment on each completed request intake (read beat, or last write beat) in either mode.
  - Saturate at all-ones.
  - cnt_clear_i together with an increment yields 1; clear alone yields 0.
- Reset mid-burst or mid-response: all state is discarded and no partial response is emitted afterwards.

Test Plan:
- RespMode=1, read src=(3,1) id=5 len=3, rsp_ready_i=1 → 4 beats starting 2 cycles after acceptance. dst=(3,1), id=5, err=2'b11, rsp_last_o only on beat 4, err_cnt=1.
- Write burst of 3 beats from (0,2) id=9, with a different id on beats 2–3 → exactly one B response with write=1, last=1, id=9, dst=(0,2).
- FifoDepth=2, rsp_ready_i=0, three reads → first two accepted, third sees req_ready_o=0. Raise rsp_ready_i → third accepted after the first pop; responses delivered in order.
- RespMode=0, 10 mixed requests → req_ready_o=1 every cycle, rsp_valid_o never 1, err_cnt=10.
- CntWidth=2, 5 transactions → counter holds at 3. cnt_clear_i coincident with an intake → 1.
- Assert rst_ni=0 after write beat 2 of 4 → outputs 0 immediately. After release, a new single-beat write returns its own id, not stale header data.
- NumChannels=2, traffic on both channels, channel 1 backpressured → channel 0 responses unaffected.
